// File: rtl/systolic_skew_feeder.sv
// Operand feeder for a DIM x DIM systolic PE array.
// Latches matrices A and B on start, then streams them into the array's left
// and top edges as a diagonally skewed wavefront. done_o pulses once the last
// PE has taken its final product.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]    a_flat_i,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]    b_flat_i,
    output logic [DIM*DATA_WIDTH-1:0]        left_o,
    output logic [DIM*DATA_WIDTH-1:0]        up_o,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int MAT_W = DIM * DIM * DATA_WIDTH;
    localparam int VEC_W = DIM * DATA_WIDTH;
    localparam int T_W   = $clog2(3 * DIM);

    // Last step carrying operands, and the last step before the done edge.
    localparam logic [T_W-1:0] T_FEED_LAST  = T_W'(2 * DIM - 2);
    localparam logic [T_W-1:0] T_DRAIN_LAST = T_W'(3 * DIM - 3);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [T_W-1:0]   t_q, t_d;
    logic [VEC_W-1:0] left_d, up_d;
    logic             done_d;
    logic             load;
    logic [MAT_W-1:0] a_q, b_q;

    // Row r of the left edge carries A[r][s-r] while that index is inside the matrix.
    function automatic logic [VEC_W-1:0] left_step(input logic [MAT_W-1:0] a, input int s);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int r = 0; r < DIM; r++) begin
            int k;
            k = s - r;
            if (k >= 0 && k < DIM)
                v[r*DATA_WIDTH +: DATA_WIDTH] = a[(r*DIM+k)*DATA_WIDTH +: DATA_WIDTH];
        end
        return v;
    endfunction

    // Column c of the top edge carries B[s-c][c] while that index is inside the matrix.
    function automatic logic [VEC_W-1:0] up_step(input logic [MAT_W-1:0] b, input int s);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int c = 0; c < DIM; c++) begin
            int k;
            k = s - c;
            if (k >= 0 && k < DIM)
                v[c*DATA_WIDTH +: DATA_WIDTH] = b[(k*DIM+c)*DATA_WIDTH +: DATA_WIDTH];
        end
        return v;
    endfunction

    // Next-state, next-step outputs and operand-capture decision.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d = state_q;
        t_d     = t_q;
        left_d  = '0;
        up_d    = '0;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Step 0 comes straight from the inputs; the latched copy is not valid yet.
                    load    = 1'b1;
                    state_d = FEED;
                    t_d     = '0;
                    left_d  = left_step(a_flat_i, 0);
                    up_d    = up_step(b_flat_i, 0);
                end
            end
            FEED: begin
                t_d = t_q + 1'b1;
                if (t_q == T_FEED_LAST) begin
                    state_d = DRAIN;
                end else begin
                    left_d = left_step(a_q, int'(t_q) + 1);
                    up_d   = up_step(b_q, int'(t_q) + 1);
                end
            end
            DRAIN: begin
                t_d = t_q + 1'b1;
                if (t_q == T_DRAIN_LAST) begin
                    state_d = IDLE;
                    t_d     = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // State, step counter and registered edge outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            state_q <= IDLE;
            t_q     <= '0;
            left_o  <= '0;
            up_o    <= '0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            left_o  <= left_d;
            up_o    <= up_d;
            done_o  <= done_d;
        end
    end

    // Operand capture at the start edge; later input changes cannot disturb a running job.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the operand store is cleared on reset so an aborted job leaves no stale data behind.
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load) begin
            a_q <= a_flat_i;
            b_q <= b_flat_i;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (DIM=4, DATA_WIDTH=32).
// A per-cycle scoreboard is filled when an accepted start is driven and drained
// one record per clock; a behavioural PE mesh checks end-to-end matrix products.
module tb_systolic_skew_feeder;

    localparam int DW   = 32;
    localparam int DIM  = 4;
    localparam int VW   = DIM * DW;
    localparam int MW   = DIM * DIM * DW;
    localparam int NREC = 3 * DIM - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [MW-1:0] a_flat_i;
    logic [MW-1:0] b_flat_i;
    logic [VW-1:0] left_o;
    logic [VW-1:0] up_o;
    logic          busy_o;
    logic          done_o;

    systolic_skew_feeder #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .a_flat_i (a_flat_i),
        .b_flat_i (b_flat_i),
        .left_o   (left_o),
        .up_o     (up_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [VW-1:0] left;
        logic [VW-1:0] up;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   total      = 0;
    int   bad        = 0;
    int   done_cnt   = 0;
    logic model_busy = 1'b0;
    logic clr_acc    = 1'b0;

    logic [DW-1:0] pa  [DIM][DIM];
    logic [DW-1:0] pb  [DIM][DIM];
    logic [DW-1:0] acc [DIM][DIM];
    logic [DW-1:0] l_in, u_in;

    // Behavioural PE mesh: operands move right/down, each PE accumulates left*up.
    always @(posedge clk_i) begin
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                l_in = (c == 0) ? left_o[r*DW +: DW] : pa[r][c-1];
                u_in = (r == 0) ? up_o[c*DW +: DW]   : pb[r-1][c];
                pa[r][c]  <= l_in;
                pb[r][c]  <= u_in;
                acc[r][c] <= (rst_i || clr_acc) ? '0 : acc[r][c] + l_in * u_in;
            end
        end
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [VW-1:0] exp_left(input logic [MW-1:0] a, input int t);
        logic [VW-1:0] v;
        v = '0;
        for (int r = 0; r < DIM; r++)
            if (t >= r && t - r < DIM) v[r*DW +: DW] = a[(r*DIM + (t-r))*DW +: DW];
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_up(input logic [MW-1:0] b, input int t);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < DIM; c++)
            if (t >= c && t - c < DIM) v[c*DW +: DW] = b[((t-c)*DIM + c)*DW +: DW];
        return v;
    endfunction

    // One record per cycle following the start edge, ending with the done cycle.
    task automatic push_job();
        exp_t e;
        for (int t = 0; t < NREC; t++) begin
            e.left = (t <= 2*DIM-2) ? exp_left(a_flat_i, t) : '0;
            e.up   = (t <= 2*DIM-2) ? exp_up(b_flat_i, t)   : '0;
            e.busy = (t < NREC-1);
            e.done = (t == NREC-1);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        if (start_i && !rst_i && !model_busy) begin
            push_job();
            clr_acc = 1'b1;
        end
        @(posedge clk_i);
        #1;
        clr_acc = 1'b0;
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.left = '0; e.up = '0; e.busy = 1'b0; e.done = 1'b0;
        end
        model_busy = e.busy;
        if (done_o === 1'b1) done_cnt++;
        check("left", left_o, e.left);
        check("up",   up_o,   e.up);
        check("busy", VW'(busy_o), VW'(e.busy));
        check("done", VW'(done_o), VW'(e.done));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) tick();
        check("sb_empty", VW'(sb.size()), '0);
    endtask

    logic [VW-1:0] x;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; a_flat_i = '0; b_flat_i = '0;

        // Reset then idle.
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (10) tick();

        // Single job with distinct element values.
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
                a_flat_i[(r*DIM+k)*DW +: DW] = DW'(16*r + k + 1);
                b_flat_i[(r*DIM+k)*DW +: DW] = DW'(16*r + k + 'h100);
            end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        x = '0; x[0 +: DW] = 32'h1;
        check("step0_left", left_o, x);
        x = '0; x[0 +: DW] = 32'h100;
        check("step0_up", up_o, x);
        repeat (3) tick();
        check("step3_row3", VW'(left_o[3*DW +: DW]), VW'(32'h31));
        check("step3_col2", VW'(up_o[2*DW +: DW]), VW'(32'h112));
        repeat (7) tick();
        check("done_e10", VW'(done_o), VW'(1'b1));

        // Integration: identity times B, then back-to-back all-twos.
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
                a_flat_i[(r*DIM+k)*DW +: DW] = (r == k) ? DW'(1) : DW'(0);
                b_flat_i[(r*DIM+k)*DW +: DW] = DW'(r*4 + k);
            end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3*DIM-2) tick();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                check($sformatf("res_id_%0d_%0d", r, c), VW'(acc[r][c]), VW'(r*4 + c));
        for (int i = 0; i < DIM*DIM; i++) begin
            a_flat_i[i*DW +: DW] = DW'(2);
            b_flat_i[i*DW +: DW] = DW'(2);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3*DIM-2) tick();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                check($sformatf("res_two_%0d_%0d", r, c), VW'(acc[r][c]), VW'(16));

        // start_i held high for 40 cycles: jobs every 3*DIM-1 cycles.
        done_cnt = 0;
        start_i  = 1'b1;
        repeat (40) tick();
        start_i = 1'b0;
        check("held_start_dones", VW'(done_cnt), VW'(3));
        drain();

        // Reset in the middle of a job.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        #2;
        rst_i = 1'b1;
        #1;
        check("abort_left", left_o, '0);
        check("abort_up",   up_o,   '0);
        check("abort_busy", VW'(busy_o), '0);
        sb.delete();
        model_busy = 1'b0;
        done_cnt   = 0;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (12) tick();
        check("abort_no_done", VW'(done_cnt), '0);

        // Fresh job after abort; operands flipped at E0+2 must not leak in.
        for (int i = 0; i < DIM*DIM; i++) begin
            a_flat_i[i*DW +: DW] = $urandom;
            b_flat_i[i*DW +: DW] = $urandom;
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (2) tick();
        a_flat_i = ~a_flat_i;
        b_flat_i = ~b_flat_i;
        drain();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
